// File: rtl/spi_word_rx.sv
// SPI slave front end: oversamples DCK/CS/MOSI, deserialises MSB-first frames into words.
// Latency: o_valid / o_eof appear 3 core clocks after the input transition is first sampled.
// Backpressure: none; every o_valid strobe must be consumed in the cycle it is presented.
module spi_word_rx #(
  parameter int c_width = 16,
  parameter int c_cntw  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_dck,
  input  logic                i_cs,
  input  logic                i_mosi,
  output logic [c_width-1:0]  o_data,
  output logic                o_valid,
  output logic                o_first,
  output logic [c_cntw-1:0]   o_index,
  output logic                o_eof,
  output logic                o_err
);

  localparam int c_bw = $clog2(c_width);
  localparam logic [c_bw-1:0] c_last = c_bw'(c_width - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  // synchroniser chains; CS idles high so its flops reset to 1
  logic dck_s1_q, dck_s2_q, dck_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  state_t              state_q, state_d;
  logic [c_bw-1:0]     bit_cnt_q, bit_cnt_d;
  logic [c_cntw-1:0]   word_cnt_q, word_cnt_d;
  logic [c_width-1:0]  shift_q, shift_d;
  logic                first_pend_q, first_pend_d;
  logic [c_width-1:0]  data_q, data_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;
  logic [c_cntw-1:0]   index_q, index_d;
  logic                eof_q, eof_d;
  logic                err_q, err_d;

  logic                rise, cs_fall, cs_rise;
  logic [c_width-1:0]  shift_next;

  assign rise    = dck_s2_q & ~dck_s3_q;
  assign cs_fall = ~cs_s2_q & cs_s3_q;
  assign cs_rise = cs_s2_q & ~cs_s3_q;

  // bring the asynchronous host lines into the core clock domain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dck_s1_q  <= 1'b0;
      dck_s2_q  <= 1'b0;
      dck_s3_q  <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      dck_s1_q  <= i_dck;
      dck_s2_q  <= dck_s1_q;
      dck_s3_q  <= dck_s2_q;
      cs_s1_q   <= i_cs;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= i_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // frame FSM: shifting, word completion and frame-end reporting
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    shift_d      = shift_q;
    first_pend_d = first_pend_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    first_d      = first_q;
    index_d      = index_q;
    eof_d        = 1'b0;
    err_d        = 1'b0;
    shift_next   = {shift_q[c_width-2:0], mosi_s2_q};
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        shift_d   = '0;
        if (cs_fall) begin
          state_d      = ST_ACTIVE;
          word_cnt_d   = '0;
          first_pend_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // CS wins over a coincident DCK edge: the edge is dropped and err uses the old count
        if (cs_rise) begin
          state_d   = ST_IDLE;
          eof_d     = 1'b1;
          err_d     = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (rise) begin
          shift_d = shift_next;
          if (bit_cnt_q == c_last) begin
            bit_cnt_d    = '0;
            data_d       = shift_next;
            valid_d      = 1'b1;
            first_d      = first_pend_q;
            index_d      = word_cnt_q;
            first_pend_d = 1'b0;
            if (word_cnt_q != '1) begin
              word_cnt_d = word_cnt_q + c_cntw'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + c_bw'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shift_q      <= '0;
      first_pend_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      index_q      <= '0;
      eof_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shift_q      <= shift_d;
      first_pend_q <= first_pend_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      first_q      <= first_d;
      index_q      <= index_d;
      eof_q        <= eof_d;
      err_q        <= err_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_first = first_q;
  assign o_index = index_q;
  assign o_eof   = eof_q;
  assign o_err   = err_q;

endmodule
